// File: rtl/tns_decoder_03.sv
// Receive-side TNS decoder: turns 3-bit crosstalk-avoidance codewords back into
// DATA_W-bit groups, flags range/history errors and packs GROUPS groups per word.
module tns_decoder_03 #(
    parameter int DATA_W = 2,
    parameter int W_A    = 2,
    parameter int W_B    = 1,
    parameter int W_C    = 1,
    parameter int GROUPS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 code_in,
    input  logic                       code_valid,
    input  logic                       sof,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          group_out,
    output logic                       group_valid,
    output logic [GROUPS*DATA_W-1:0]   word_out,
    output logic                       word_valid,
    output logic                       err_range,
    output logic                       err_seq,
    output logic                       err_sticky
);

    localparam int SUM_W  = $clog2(W_A + W_B + 2);
    localparam int CNT_W  = $clog2(GROUPS);
    localparam int WORD_W = GROUPS * DATA_W;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic logic [SUM_W-1:0] decode_sum(input logic [2:0] c);
        int s;
        s = (c[2] ? W_A : 0) + (c[1] ? W_B : 0) + (c[0] ? 1 : 0);
        return SUM_W'(s);
    endfunction

    function automatic logic range_err(input logic [SUM_W-1:0] s);
        return int'(s) > ((1 << DATA_W) - 1);
    endfunction

    // Inside this band the encoder repeats its previous c2, so a flip is illegal.
    function automatic logic in_band(input logic [SUM_W-1:0] s);
        return (int'(s) >= W_A) && (int'(s) < (W_A + W_C));
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   slots_q, slots_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                wvld_q, wvld_d;
    logic [DATA_W-1:0]   group_q, group_d;
    logic                gvld_q, gvld_d;
    logic                erange_q, erange_d;
    logic                eseq_q, eseq_d;
    logic                sticky_q, sticky_d;
    logic                prev_c2_q, prev_c2_d;
    logic                first_q, first_d;

    logic [SUM_W-1:0]    sum;
    logic [DATA_W-1:0]   grp;
    logic                e_rng;
    logic                e_seq;

    always_comb begin
        sum   = decode_sum(code_in);
        grp   = DATA_W'(sum);
        e_rng = range_err(sum);
        e_seq = in_band(sum) && !first_q && (code_in[2] != prev_c2_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slots_d   = slots_q;
        word_d    = word_q;
        wvld_d    = 1'b0;
        group_d   = group_q;
        gvld_d    = 1'b0;
        erange_d  = 1'b0;
        eseq_d    = 1'b0;
        prev_c2_d = prev_c2_q;
        first_d   = first_q;
        // A same-cycle error overrides the clear.
        sticky_d  = clr_err ? 1'b0 : sticky_q;

        if (code_valid) begin
            group_d   = grp;
            gvld_d    = 1'b1;
            erange_d  = e_rng;
            eseq_d    = e_seq;
            prev_c2_d = code_in[2];
            first_d   = 1'b0;
            sticky_d  = sticky_d | e_rng | e_seq;

            if (sof) begin
                slots_d[DATA_W-1:0] = grp;
                cnt_d               = CNT_W'(1);
                state_d             = COLLECT;
            end else if (state_q == COLLECT) begin
                slots_d[int'(cnt_q)*DATA_W +: DATA_W] = grp;
                if (cnt_q == CNT_W'(GROUPS - 1)) begin
                    word_d = slots_d;
                    wvld_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slots_q   <= '0;
            word_q    <= '0;
            wvld_q    <= 1'b0;
            group_q   <= '0;
            gvld_q    <= 1'b0;
            erange_q  <= 1'b0;
            eseq_q    <= 1'b0;
            sticky_q  <= 1'b0;
            prev_c2_q <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slots_q   <= slots_d;
            word_q    <= word_d;
            wvld_q    <= wvld_d;
            group_q   <= group_d;
            gvld_q    <= gvld_d;
            erange_q  <= erange_d;
            eseq_q    <= eseq_d;
            sticky_q  <= sticky_d;
            prev_c2_q <= prev_c2_d;
            first_q   <= first_d;
        end
    end

    assign group_out   = group_q;
    assign group_valid = gvld_q;
    assign word_out    = word_q;
    assign word_valid  = wvld_q;
    assign err_range   = erange_q;
    assign err_seq     = eseq_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_tns_decoder_03.sv
// Scoreboard bench for tns_decoder_03: directed codewords with hand-computed
// group/word expectations, popped by a monitor whenever the DUT pulses.
module tb_tns_decoder_03;

    localparam int DATA_W = 2;
    localparam int GROUPS = 4;
    localparam int WORD_W = DATA_W * GROUPS;

    logic              clock = 1'b0;
    logic              reset;
    logic [2:0]        code_in;
    logic              code_valid;
    logic              sof;
    logic              clr_err;
    logic [DATA_W-1:0] group_out;
    logic              group_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              err_range;
    logic              err_seq;
    logic              err_sticky;

    tns_decoder_03 #(.DATA_W(DATA_W), .W_A(2), .W_B(1), .W_C(1), .GROUPS(GROUPS)) dut (
        .clock       (clock),
        .reset       (reset),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .sof         (sof),
        .clr_err     (clr_err),
        .group_out   (group_out),
        .group_valid (group_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .err_range   (err_range),
        .err_seq     (err_seq),
        .err_sticky  (err_sticky)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] g;
        logic       er;
        logic       es;
    } exp_t;

    exp_t              gq[$];
    logic [WORD_W-1:0] wq[$];
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic s,
                        input logic [1:0] g, input logic er, input logic es);
        @(posedge clock);
        #1;
        code_in    = c;
        code_valid = 1'b1;
        sof        = s;
        clr_err    = 1'b0;
        gq.push_back('{g: g, er: er, es: es});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            code_valid = 1'b0;
            sof        = 1'b0;
            clr_err    = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clock);
        #1;
        code_valid = 1'b0;
        sof        = 1'b0;
        clr_err    = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        code_valid = 1'b0;
        sof        = 1'b0;
        clr_err    = 1'b0;
        reset      = 1'b1;
        #2;
        reset      = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_group_out"},   32'(group_out),   32'd0);
        chk({tag, "_group_valid"}, 32'(group_valid), 32'd0);
        chk({tag, "_word_out"},    32'(word_out),    32'd0);
        chk({tag, "_word_valid"},  32'(word_valid),  32'd0);
        chk({tag, "_err_range"},   32'(err_range),   32'd0);
        chk({tag, "_err_seq"},     32'(err_seq),     32'd0);
        chk({tag, "_err_sticky"},  32'(err_sticky),  32'd0);
    endtask

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clock) begin
        exp_t e;
        if (group_valid) begin
            if (gq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL group_unexpected: got group_out=%0d, expected no pulse", group_out);
            end else begin
                e = gq.pop_front();
                chk("group_out", 32'(group_out), 32'(e.g));
                chk("err_range", 32'(err_range), 32'(e.er));
                chk("err_seq",   32'(err_seq),   32'(e.es));
            end
        end else if (err_range || err_seq) begin
            chk("err_without_group_valid", 32'({err_range, err_seq}), 32'd0);
        end
        if (word_valid) begin
            chk("word_with_last_group", 32'(group_valid), 32'd1);
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL word_unexpected: got word_out=%0h, expected no pulse", word_out);
            end else begin
                chk("word_out", 32'(word_out), 32'(wq.pop_front()));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        code_in    = 3'b000;
        code_valid = 1'b0;
        sof        = 1'b0;
        clr_err    = 1'b0;
        #12;
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Test 1: basic frame 0,1,2,3
        wq.push_back(8'hE4);
        send(3'b000, 1'b1, 2'd0, 1'b0, 1'b0);
        send(3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
        send(3'b011, 1'b0, 2'd2, 1'b0, 1'b0);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        idle(2);

        // Test 2: history check, first codeword exempt
        do_reset();
        send(3'b100, 1'b0, 2'd2, 1'b0, 1'b0);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        send(3'b011, 1'b0, 2'd2, 1'b0, 1'b1);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        send(3'b100, 1'b0, 2'd2, 1'b0, 1'b0);
        idle(2);
        chk("sticky_after_seq", 32'(err_sticky), 32'd1);

        // Test 3: range error, clr_err, clr_err colliding with an error
        do_reset();
        send(3'b111, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(1);
        chk("sticky_after_range", 32'(err_sticky), 32'd1);
        pulse_clr();
        idle(1);
        chk("sticky_cleared", 32'(err_sticky), 32'd0);
        send(3'b111, 1'b0, 2'd0, 1'b1, 1'b0);
        clr_err = 1'b1;
        idle(1);
        chk("sticky_err_beats_clr", 32'(err_sticky), 32'd1);
        pulse_clr();
        idle(1);
        chk("sticky_cleared_again", 32'(err_sticky), 32'd0);

        // Test 4: mid-word sof discards the partial word
        do_reset();
        wq.push_back(8'h1B);
        send(3'b000, 1'b1, 2'd0, 1'b0, 1'b0);
        send(3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
        send(3'b110, 1'b1, 2'd3, 1'b0, 1'b0);
        send(3'b011, 1'b0, 2'd2, 1'b0, 1'b1);
        send(3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
        send(3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
        idle(2);

        // Test 5: continuous framing, then hold
        do_reset();
        wq.push_back(8'hE4);
        wq.push_back(8'h76);
        send(3'b000, 1'b1, 2'd0, 1'b0, 1'b0);
        send(3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
        send(3'b011, 1'b0, 2'd2, 1'b0, 1'b0);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        send(3'b100, 1'b0, 2'd2, 1'b0, 1'b0);
        send(3'b001, 1'b0, 2'd1, 1'b0, 1'b0);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        send(3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
        idle(4);
        chk("word_out_held",  32'(word_out),  32'h76);
        chk("group_out_held", 32'(group_out), 32'd1);

        // Test 6: asynchronous reset mid-word
        send(3'b000, 1'b1, 2'd0, 1'b0, 1'b0);
        send(3'b111, 1'b0, 2'd0, 1'b1, 1'b0);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        code_valid = 1'b0;
        sof        = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        #1;
        reset = 1'b0;
        wq.push_back(8'hC6);
        send(3'b011, 1'b1, 2'd2, 1'b0, 1'b0);
        send(3'b010, 1'b0, 2'd1, 1'b0, 1'b0);
        send(3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
        send(3'b110, 1'b0, 2'd3, 1'b0, 1'b0);
        idle(3);

        chk("group_queue_drained", 32'(gq.size()), 32'd0);
        chk("word_queue_drained",  32'(wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tns_decoder_03.md
Name: tns_decoder_03

Overview:
- Receive-side counterpart of the 3-bit TNS crosstalk-avoidance encoder.
- Takes one 3-bit codeword per valid cycle from the bus and reconstructs the DATA_W-bit group value as c2*W_A + c1*W_B + c0.
- Checks each codeword for range and history-consistency errors.
- Reassembles GROUPS consecutive groups into one wide data word for the downstream datapath.

Parameters:
- DATA_W, 2, bits per group; legal decoded value range is 0..2^DATA_W-1.
- W_A, 2, weight of code bit 2.
- W_B, 1, weight of code bit 1. Code bit 0 has weight 1.
- W_C, 1, width of the ambiguous band [W_A, W_A+W_C). In this band the encoder repeats its previous bit 2.
- GROUPS, 4, groups per output word. Must be at least 2.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- code_in  in  3  codeword {c2,c1,c0} from the bus.
- code_valid  in  1  code_in is valid this cycle.
- sof  in  1  start of frame; qualified by code_valid; the current codeword is group 0.
- clr_err  in  1  synchronous clear of err_sticky.
- group_out  out  DATA_W  decoded group value (registered).
- group_valid  out  1  one-cycle pulse; group_out is valid.
- word_out  out  GROUPS*DATA_W  assembled word; group 0 in the LSBs.
- word_valid  out  1  one-cycle pulse; word_out is valid.
- err_range  out  1  pulses with group_valid when the decoded sum exceeds 2^DATA_W-1.
- err_seq  out  1  pulses with group_valid when the ambiguous-band rule is violated.
- err_sticky  out  1  OR of all error pulses since the last reset or clr_err.

Behaviour:
- Reset (async, active-high) forces every output to 0. It also clears:
  - the group counter;
  - prev_c2 (set to 0, matching the encoder's power-up history bit);
  - first_flag (set to 1, meaning the history check is disabled);
  - the FSM, which goes to IDLE.
- Decode arithmetic:
  - sum = c2*W_A + c1*W_B + c0, computed at width clog2(W_A+W_B+2).
  - group_out takes the low DATA_W bits of sum.
  - err_range = (sum > 2^DATA_W-1).
- Sequence check: when sum is inside [W_A, W_A+W_C), first_flag is 0 and c2 != prev_c2, err_seq = 1.
  - prev_c2 updates to c2 on every accepted codeword.
  - first_flag clears after the first accepted codeword.
- Latency: group_out, group_valid and both error pulses are registered one cycle after the accepting code_valid edge.
- With code_valid low, group_valid = 0. group_out and word_out hold their values.
- FSM:
  - IDLE: waits for code_valid with sof. Codewords without sof in IDLE are decoded and error-checked (group_valid pulses) but are not placed in the word.
  - On sof, the group is stored in slot 0, the counter is set to 1 and the FSM goes to COLLECT.
  - COLLECT: each valid codeword is stored in slot [cnt] and cnt increments.
  - When cnt == GROUPS-1 is accepted:
    - word_out loads the full word (new group included);
    - word_valid pulses in the same cycle as the last group_valid;
    - cnt wraps to 0 and the FSM stays in COLLECT. Continuous framing needs no further sof.
- sof during COLLECT (mid-word):
  - the partial word is discarded with no word_valid;
  - the current codeword becomes slot 0 and cnt = 1;
  - err_seq history is kept, because the bus stream is continuous.
- Errored groups are still stored in the word; flagging is the only action taken.
- clr_err and a new error in the same cycle: the error wins, so err_sticky = 1.
- Reset mid-word drops the partial word and returns to IDLE.

Test Plan:
1. Reset, then sof + code_in sequence 000, 010, 011, 110 (all valid) -> group_out sequence 0, 1, 2, 3 with no errors. word_valid pulses once with word_out = 8'b11_10_01_00, one cycle after the 4th codeword.
2. After reset, code_in 110 then 011 -> second group decodes to 2; err_seq = 1 because prev_c2 = 1, the value is in band [2,3) and c2 = 0. Repeat as 110 then 100 -> value 2 with no error.
3. code_in 111 -> group_out = 0 (low 2 bits of 4), err_range = 1, err_sticky sets. Assert clr_err with no new error -> err_sticky = 0 the next cycle.
4. sof, then 2 codewords, then sof again, then 4 codewords -> exactly one word_valid, after the last 4, containing only those 4 groups.
5. 8 back-to-back valid codewords after a single sof -> two word_valid pulses, 4 cycles apart. Then hold code_valid low for 3 cycles -> no pulses and word_out held.
6. Assert reset asynchronously between clock edges after 3 groups -> all outputs go to 0 immediately. The next sof starts a fresh word, and a first codeword 011 gives no err_seq.
